// File: rtl/btn_event_pkg.sv
// Shared definitions for the button event classifier: FSM state encoding,
// default timing constants and a small constant-evaluation helper.
package btn_event_pkg;

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        PRESSED        = 3'd1,
        LONG_HELD      = 3'd2,
        WAIT_SECOND    = 3'd3,
        SECOND_PRESSED = 3'd4
    } btn_state_e;

    localparam int unsigned DEF_CLK_FREQ   = 32'd100_000_000;
    localparam int unsigned DEF_TICK_HZ    = 32'd1000;
    localparam int unsigned DEF_LONG_MS    = 32'd1000;
    localparam int unsigned DEF_DOUBLE_MS  = 32'd300;
    localparam int unsigned DEF_REPEAT_MS  = 32'd100;
    localparam logic        DEF_INIT_LEVEL = 1'b0;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tick_timebase.sv
// Prescaler producing a one-cycle tick every DIV clocks, plus a saturating
// tick counter; both restart from zero whenever clear is asserted.
module tick_timebase #(
    parameter int unsigned DIV   = 32'd10,
    parameter int unsigned CNT_W = 32'd4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    output logic             tick,
    output logic [CNT_W-1:0] tick_cnt
);

    localparam int unsigned      PRE_W    = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 32'd1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    logic [PRE_W-1:0] presc_q;
    logic [CNT_W-1:0] cnt_q;

    assign tick     = (presc_q == PRE_LAST);
    assign tick_cnt = cnt_q;

    // Prescaler wraps at terminal count; tick counter holds at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else if (clear) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= tick ? '0 : (presc_q + PRE_ONE);
            if (tick && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/button_event_classifier.sv
// Turns a debounced switch level into press/release/short/long/double-click
// pulses. Define BUTTON_AUTO_REPEAT_EN to enable auto-repeat while long-held.
module button_event_classifier
    import btn_event_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
    parameter int unsigned TICK_HZ    = DEF_TICK_HZ,
    parameter int unsigned LONG_MS    = DEF_LONG_MS,
    parameter int unsigned DOUBLE_MS  = DEF_DOUBLE_MS,
    parameter int unsigned REPEAT_MS  = DEF_REPEAT_MS,
    parameter logic        INIT_LEVEL = DEF_INIT_LEVEL
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic held,
    output logic repeat_pulse
);

    localparam int unsigned      DIV      = CLK_FREQ / TICK_HZ;
    localparam int unsigned      CNT_W    = $clog2(max3(LONG_MS, DOUBLE_MS, REPEAT_MS) + 32'd1);
    localparam logic [CNT_W-1:0] LONG_C   = CNT_W'(LONG_MS);
    localparam logic [CNT_W-1:0] DOUBLE_C = CNT_W'(DOUBLE_MS);

    btn_state_e       state_q, state_d;
    logic             sw_q;
    logic             rise, fall, tick, clear, rep_hit;
    logic [CNT_W-1:0] tick_cnt;
    logic press_q, release_q, short_q, long_q, double_q, held_q, repeat_q;
    logic press_d, release_d, short_d, long_d, double_d, held_d, repeat_d;

    assign rise = sw_level & ~sw_q;
    assign fall = ~sw_level & sw_q;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST_C = CNT_W'(REPEAT_MS - 32'd1);
    // Fire on the tick that would make the count reach REPEAT_MS, so the
    // restart lines up with the prescaler wrap and the period stays exact.
    assign rep_hit = (state_q == LONG_HELD) && tick && (tick_cnt == REP_LAST_C);
`else
    logic unused_tick;
    assign unused_tick = tick;
    assign rep_hit     = 1'b0;
`endif

    assign clear = (state_d != state_q) || rep_hit;

    tick_timebase #(.DIV(DIV), .CNT_W(CNT_W)) u_timebase (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .tick     (tick),
        .tick_cnt (tick_cnt)
    );

    // Next-state and pulse decode; level edges take priority over timeouts.
    always_comb begin
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        double_d  = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_d   = WAIT_SECOND;
                    release_d = 1'b1;
                end else if (tick_cnt == LONG_C) begin
                    state_d = LONG_HELD;
                    long_d  = 1'b1;
                end else begin
                    state_d = PRESSED;
                end
            end
            LONG_HELD: begin
                if (fall) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else if (rep_hit) begin
                    repeat_d = 1'b1;
                end else begin
                    state_d = LONG_HELD;
                end
            end
            WAIT_SECOND: begin
                if (rise) begin
                    state_d  = SECOND_PRESSED;
                    press_d  = 1'b1;
                    double_d = 1'b1;
                end else if (tick_cnt == DOUBLE_C) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                end else begin
                    state_d = WAIT_SECOND;
                end
            end
            SECOND_PRESSED: begin
                if (fall) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else begin
                    state_d = SECOND_PRESSED;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        held_d = (state_d == PRESSED) || (state_d == LONG_HELD) || (state_d == SECOND_PRESSED);
    end

    // State, edge-detect history and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sw_q      <= INIT_LEVEL;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            double_q  <= 1'b0;
            held_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sw_q      <= sw_level;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            long_q    <= long_d;
            double_q  <= double_d;
            held_q    <= held_d;
            repeat_q  <= repeat_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign short_press   = short_q;
    assign long_press    = long_q;
    assign double_click  = double_q;
    assign held          = held_q;
    assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_button_event_classifier.sv
// Scoreboard bench: each planned press pushes its expected pulses (edge index
// and pulse set); a negedge monitor pops and compares whenever a pulse appears.
module tb_button_event_classifier;

    localparam int unsigned CLK_FREQ  = 1000;
    localparam int unsigned TICK_HZ   = 100;
    localparam int unsigned LONG_MS   = 20;
    localparam int unsigned DOUBLE_MS = 5;
    localparam int unsigned REPEAT_MS = 4;

    localparam int DIV     = CLK_FREQ / TICK_HZ;
    // Edges from the sampled rise to long_press; a hold must exceed this to be long.
    localparam int LONG_AT = LONG_MS * DIV + 1;
    // Edges from the sampled fall to the double-click timeout (rise on it still counts).
    localparam int DBL_WIN = DOUBLE_MS * DIV + 1;
    localparam int REP_PER = REPEAT_MS * DIV;

    localparam logic [5:0] EV_PRESS = 6'b000001;
    localparam logic [5:0] EV_REL   = 6'b000010;
    localparam logic [5:0] EV_SHORT = 6'b000100;
    localparam logic [5:0] EV_LONG  = 6'b001000;
    localparam logic [5:0] EV_DBL   = 6'b010000;
    localparam logic [5:0] EV_REP   = 6'b100000;

    typedef struct {
        int         cyc;
        logic [5:0] ev;
    } exp_t;

    exp_t exp_q[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sw = 1'b0;
    logic sw_hi = 1'b1;
    logic press_pulse, release_pulse, short_press, long_press, double_click, held, repeat_pulse;
    logic hi_press, hi_release, hi_short, hi_long, hi_double, hi_held, hi_repeat;

    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    logic lvl_smp = 1'b0;
    bit   second = 1'b0;
    bit   done = 1'b0;
    bit   end_checked = 1'b0;

    button_event_classifier #(
        .CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ), .LONG_MS(LONG_MS),
        .DOUBLE_MS(DOUBLE_MS), .REPEAT_MS(REPEAT_MS), .INIT_LEVEL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .sw_level(sw),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .short_press(short_press), .long_press(long_press),
        .double_click(double_click), .held(held), .repeat_pulse(repeat_pulse)
    );

    // Second instance: switch already high across reset must not look like a press.
    button_event_classifier #(
        .CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ), .LONG_MS(LONG_MS),
        .DOUBLE_MS(DOUBLE_MS), .REPEAT_MS(REPEAT_MS), .INIT_LEVEL(1'b1)
    ) dut_hi (
        .clk(clk), .rst(rst), .sw_level(sw_hi),
        .press_pulse(hi_press), .release_pulse(hi_release),
        .short_press(hi_short), .long_press(hi_long),
        .double_click(hi_double), .held(hi_held), .repeat_pulse(hi_repeat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        lvl_smp <= sw;
    end

    // Monitor: held follows the sampled level, pulses are matched to the queue.
    always @(negedge clk) begin
        logic [5:0] ev;
        logic [6:0] hi_all;
        exp_t       e;
        ev     = {repeat_pulse, double_click, long_press, short_press, release_pulse, press_pulse};
        hi_all = {hi_press, hi_release, hi_short, hi_long, hi_double, hi_held, hi_repeat};

        checks++;
        if (held === (lvl_smp & ~rst)) passes++;
        else $display("FAIL held: cycle %0d got %b want %b", cyc, held, lvl_smp & ~rst);

        checks++;
        if (hi_all === 7'd0) passes++;
        else $display("FAIL init_level_hi: cycle %0d outputs %b want 0000000", cyc, hi_all);

        if (ev !== 6'd0) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL event: cycle %0d got %b, nothing expected", cyc, ev);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc == cyc && e.ev === ev) passes++;
                else $display("FAIL event: got %b at cycle %0d, want %b at cycle %0d",
                              ev, cyc, e.ev, e.cyc);
            end
        end

        if (done && !end_checked) begin
            end_checked = 1'b1;
            checks++;
            if (exp_q.size() == 0) passes++;
            else $display("FAIL missing_events: %0d left, next %b at cycle %0d",
                          exp_q.size(), exp_q[0].ev, exp_q[0].cyc);
        end
    end

    task automatic push(input int c, input logic [5:0] ev);
        exp_t e;
        e.cyc = c;
        e.ev  = ev;
        exp_q.push_back(e);
    endtask

    // Hold high for h edges then low for lo edges; called #1 after a posedge.
    task automatic press(input int h, input int lo);
        int r, f;
        r = cyc + 1;
        f = r + h;
        if (second) begin
            push(r, EV_PRESS | EV_DBL);
            push(f, EV_REL);
            second = 1'b0;
        end else begin
            push(r, EV_PRESS);
            if (h > LONG_AT) begin
                push(r + LONG_AT, EV_LONG);
`ifdef BUTTON_AUTO_REPEAT_EN
                for (int t = r + LONG_AT + REP_PER; t < f; t += REP_PER) push(t, EV_REP);
`endif
                push(f, EV_REL);
            end else begin
                push(f, EV_REL);
                if (lo <= DBL_WIN) second = 1'b1;
                else push(f + DBL_WIN, EV_SHORT);
            end
        end
        sw = 1'b1;
        repeat (h) @(posedge clk);
        #1;
        sw = 1'b0;
        repeat (lo) @(posedge clk);
        #1;
    endtask

    initial begin
        int r, h, lo;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        press(50, 120);
        press(250, 80);
        press(30, 20);
        press(30, 80);
        press(LONG_AT, 80);
        press(LONG_AT + 1, 80);
        press(30, DBL_WIN);
        press(30, 80);
        press(30, DBL_WIN + 1);
        press(400, 80);

        // Reset while waiting for a second press: the pending short is dropped.
        r = cyc + 1;
        push(r, EV_PRESS);
        push(r + 30, EV_REL);
        sw = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        sw = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        second = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;

        for (int i = 0; i < 25; i++) begin
            h  = ($urandom_range(0, 3) == 0) ? $urandom_range(LONG_AT - 5, LONG_AT + 5)
                                             : $urandom_range(1, 260);
            lo = ($urandom_range(0, 2) == 0) ? $urandom_range(DBL_WIN - 4, DBL_WIN + 4)
                                             : $urandom_range(1, 90);
            if (i == 24) lo = 80;
            press(h, lo);
        end

        repeat (20) @(posedge clk);
        #1;
        done = 1'b1;
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
